target_gen_param: RTL and testbench

TARGET_GEN_PARAM -- requirements
Module: target_gen_param

---
 rtl/snake_pkg.sv | 38 +++
 rtl/lfsr_gen.sv | 28 ++
 rtl/target_gen_param.sv | 162 ++++++++++++++++
 tb/tb_target_gen_param.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: master-state encodings, default grid size and LFSR tap masks
// shared by the snake game blocks.
package snake_pkg;

    typedef enum logic [1:0] {
        MSM_IDLE = 2'b00,
        MSM_PLAY = 2'b01,
        MSM_WIN  = 2'b10,
        MSM_LOSE = 2'b11
    } msm_state_t;

    localparam int GRID_X_MAX = 160;
    localparam int GRID_Y_MAX = 120;

    // Maximal-length tap masks; bit n-1 set means stage n feeds the XNOR.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen: free-running XNOR Fibonacci LFSR; all-zeros is a legal seed
// (the lock-up state is all-ones), so reset simply clears it.
module lfsr_gen
    import snake_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [WIDTH-1:0] o_value
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] r_state;
    logic             w_feedback;

    assign w_feedback = ~^(r_state & TAPS);
    assign o_value    = r_state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= '0;
        end else begin
            r_state <= {r_state[WIDTH-2:0], w_feedback};
        end
    end

endmodule

// File: rtl/target_gen_param.sv
// target_gen_param: rejection-samples a random grid cell as the next snake target.
// Define TARGET_OCC_CHECK_EN to also reject cells reported occupied via OCC_QUERY/OCC_HIT.
module target_gen_param
    import snake_pkg::*;
#(
    parameter int X_WIDTH   = 8,
    parameter int Y_WIDTH   = 7,
    parameter int X_MAX     = GRID_X_MAX,
    parameter int Y_MAX     = GRID_Y_MAX,
    parameter int MAX_TRIES = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       REACHED_TARGET,
    input  logic [1:0]                 MSM_State,
    input  logic                       OCC_HIT,
    output logic                       OCC_QUERY,
    output logic [X_WIDTH+Y_WIDTH-1:0] OCC_ADDR,
    output logic [X_WIDTH+Y_WIDTH-1:0] TARGET_ADDR,
    output logic                       TARGET_VALID,
    output logic                       FALLBACK,
    output logic [1:0]                 o_dbg_state
);
    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_DRAW  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
`ifdef TARGET_OCC_CHECK_EN
    localparam logic [1:0] S_WAIT_OCC = 2'd3;
`endif

    localparam int XL = X_WIDTH + 1;
    localparam int YL = Y_WIDTH + 1;
    localparam logic [X_WIDTH:0]   X_LIM   = XL'(X_MAX);
    localparam logic [Y_WIDTH:0]   Y_LIM   = YL'(Y_MAX);
    localparam logic [X_WIDTH-1:0] X_SUB   = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0] Y_SUB   = Y_WIDTH'(Y_MAX);
    localparam logic [7:0]         TRY_LIM = 8'(MAX_TRIES);

    logic [1:0]                   r_state;
    logic [7:0]                   r_tries;
    logic [X_WIDTH-1:0]           r_cx;
    logic [Y_WIDTH-1:0]           r_cy;
    logic [X_WIDTH+Y_WIDTH-1:0]   r_target_addr;
    logic                         r_target_valid;
    logic                         r_fallback;

    logic [X_WIDTH-1:0] w_lfsr_x;
    logic [Y_WIDTH-1:0] w_lfsr_y;
    logic [X_WIDTH-1:0] w_fix_x;
    logic [Y_WIDTH-1:0] w_fix_y;
    logic               w_cx_ok;
    logic               w_cy_ok;
    logic               w_cand_ok;
    logic               w_force;
    logic               w_start;
    logic               w_accept;
    logic [7:0]         w_tries_inc;

    lfsr_gen #(.WIDTH(X_WIDTH)) u_lfsr_x (.i_clk(CLK), .i_rst(RESET), .o_value(w_lfsr_x));
    lfsr_gen #(.WIDTH(Y_WIDTH)) u_lfsr_y (.i_clk(CLK), .i_rst(RESET), .o_value(w_lfsr_y));

    assign w_cx_ok     = ({1'b0, r_cx} < X_LIM);
    assign w_cy_ok     = ({1'b0, r_cy} < Y_LIM);
    assign w_cand_ok   = w_cx_ok && w_cy_ok;
    // Out-of-range coordinates sit below 2*MAX, so one subtraction folds them back in.
    assign w_fix_x     = w_cx_ok ? r_cx : r_cx - X_SUB;
    assign w_fix_y     = w_cy_ok ? r_cy : r_cy - Y_SUB;
    assign w_force     = (r_tries >= TRY_LIM);
    assign w_start     = REACHED_TARGET || (MSM_State == MSM_IDLE);
    assign w_tries_inc = r_tries + 8'd1;

    assign TARGET_ADDR  = r_target_addr;
    assign TARGET_VALID = r_target_valid;
    assign FALLBACK     = r_fallback;
    assign o_dbg_state  = r_state;

    always_comb begin
        w_accept = 1'b0;
        case (r_state)
`ifdef TARGET_OCC_CHECK_EN
            S_CHECK:    w_accept = w_force;
            S_WAIT_OCC: w_accept = !OCC_HIT;
`else
            S_CHECK:    w_accept = w_force || w_cand_ok;
`endif
            default:    w_accept = 1'b0;
        endcase
    end

`ifdef TARGET_OCC_CHECK_EN
    // The query is issued while still in DRAW so OCC_HIT lands in WAIT_OCC,
    // one cycle after the strobe; forced draws skip the query entirely.
    logic                       r_occ_query;
    logic [X_WIDTH+Y_WIDTH-1:0] r_occ_addr;
    logic                       w_query_now;

    assign w_query_now = (r_state == S_DRAW) && ({1'b0, w_lfsr_x} < X_LIM) &&
                         ({1'b0, w_lfsr_y} < Y_LIM) && (w_tries_inc < TRY_LIM);
    assign OCC_QUERY   = r_occ_query;
    assign OCC_ADDR    = r_occ_addr;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_occ_query <= 1'b0;
            r_occ_addr  <= '0;
        end else begin
            r_occ_query <= w_query_now;
            if (w_query_now) begin
                r_occ_addr <= {w_lfsr_x, w_lfsr_y};
            end
        end
    end
`else
    logic w_unused_occ_hit;

    assign w_unused_occ_hit = OCC_HIT;
    assign OCC_QUERY        = 1'b0;
    assign OCC_ADDR         = '0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state        <= S_HOLD;
            r_tries        <= '0;
            r_cx           <= '0;
            r_cy           <= '0;
            r_target_addr  <= '0;
            r_target_valid <= 1'b0;
            r_fallback     <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (w_start) begin
                        r_state        <= S_DRAW;
                        r_target_valid <= 1'b0;
                    end
                end
                S_DRAW: begin
                    r_cx    <= w_lfsr_x;
                    r_cy    <= w_lfsr_y;
                    r_tries <= w_tries_inc;
                    r_state <= S_CHECK;
                end
`ifdef TARGET_OCC_CHECK_EN
                S_CHECK:    r_state <= w_cand_ok ? S_WAIT_OCC : S_DRAW;
                S_WAIT_OCC: r_state <= S_DRAW;
`else
                S_CHECK:    r_state <= S_DRAW;
`endif
                default:    r_state <= S_HOLD;
            endcase
            if (w_accept) begin
                r_target_addr  <= {w_fix_x, w_fix_y};
                r_target_valid <= 1'b1;
                r_fallback     <= w_force;
                r_tries        <= '0;
                r_state        <= S_HOLD;
            end
        end
    end

endmodule

// File: tb/tb_target_gen_param.sv
// tb_target_gen_param: directed bench for target_gen_param with an accept scoreboard.
// Builds with or without TARGET_OCC_CHECK_EN; expectations follow the build.
module tb_target_gen_param;
    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int AW   = XW + YW;
    localparam int MT   = 4;
    localparam int SB_W = 1 + 1 + 8 + AW;
`ifdef TARGET_OCC_CHECK_EN
    localparam int LAT    = 4;
    localparam int OCC_EN = 1;
`else
    localparam int LAT    = 3;
    localparam int OCC_EN = 0;
`endif

    logic          clk;
    logic          rst;
    logic          reached;
    logic [1:0]    msm;
    logic          occ_hit;
    logic          occ_query;
    logic [AW-1:0] occ_addr;
    logic [AW-1:0] target_addr;
    logic          target_valid;
    logic          fallback;
    logic [1:0]    dbg_state;

    int checks;
    int failures;
    int cyc;
    int occ_cnt;
    int idle_accepts;
    bit idle_phase;
    logic [XW-1:0] f_x;
    logic [YW-1:0] f_y;

    // Entry layout: {exact, fallback, latency[7:0], addr}
    logic [SB_W-1:0] exp_q[$];
    int              iss_q[$];

    target_gen_param #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .X_MAX(160), .Y_MAX(120), .MAX_TRIES(MT)
    ) dut (
        .CLK(clk), .RESET(rst), .REACHED_TARGET(reached), .MSM_State(msm),
        .OCC_HIT(occ_hit), .OCC_QUERY(occ_query), .OCC_ADDR(occ_addr),
        .TARGET_ADDR(target_addr), .TARGET_VALID(target_valid),
        .FALLBACK(fallback), .o_dbg_state(dbg_state)
    );

    // Clock / cycle counter / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, required to finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        occ_cnt = 0;
        forever begin
            @(negedge clk);
            if (occ_query) occ_cnt++;
        end
    end

    function automatic logic [AW-1:0] xy(input int x, input int y);
        return {XW'(x), YW'(y)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops one expectation per rising TARGET_VALID
    initial begin
        logic            prev_v;
        logic [SB_W-1:0] e;
        int              iss;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (target_valid && !prev_v) begin
                if (idle_phase) begin
                    idle_accepts++;
                    check("idle_x_in_range", 32'(target_addr[AW-1:YW] < XW'(160)), 1);
                    check("idle_y_in_range", 32'(target_addr[YW-1:0] < YW'(120)), 1);
                end else if (exp_q.size() == 0) begin
                    check("accept_with_empty_queue", 32'(exp_q.size()), 1);
                end else begin
                    e   = exp_q.pop_front();
                    iss = iss_q.pop_front();
                    if (e[SB_W-1]) begin
                        check("target_addr", 32'(target_addr), 32'(e[AW-1:0]));
                        check("latency", cyc - iss, 32'(e[AW+7:AW]));
                    end else begin
                        check("x_in_range", 32'(target_addr[AW-1:YW] < XW'(160)), 1);
                        check("y_in_range", 32'(target_addr[YW-1:0] < YW'(120)), 1);
                        check("latency_min", 32'((cyc - iss) >= LAT), 1);
                    end
                    check("fallback", 32'(fallback), 32'(e[SB_W-2]));
                end
            end
            prev_v = target_valid;
        end
    end

    // Driver tasks
    task automatic set_lfsr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        f_x = x;
        f_y = y;
        force dut.w_lfsr_x = f_x;
        force dut.w_lfsr_y = f_y;
    endtask

    // First draw sees (x1,y1); from the second draw on the LFSRs read (x2,y2).
    // Returns in the CHECK cycle of the first draw.
    task automatic issue(input int x1, input int y1, input int x2, input int y2,
                         input logic [AW-1:0] exp_addr, input logic fb, input int lat);
        @(negedge clk);
        set_lfsr(XW'(x1), YW'(y1));
        reached = 1'b1;
        exp_q.push_back({1'b1, fb, 8'(lat), exp_addr});
        iss_q.push_back(cyc);
        @(negedge clk);
        reached = 1'b0;
        @(negedge clk);
        set_lfsr(XW'(x2), YW'(y2));
    endtask

    task automatic issue_free();
        @(negedge clk);
        reached = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 8'd0, {AW{1'b0}}});
        iss_q.push_back(cyc);
        @(negedge clk);
        reached = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int base;
        int changes;
        logic [AW-1:0] last;
        checks       = 0;
        failures     = 0;
        idle_accepts = 0;
        idle_phase   = 1'b0;
        rst          = 1'b1;
        reached      = 1'b0;
        msm          = 2'b01;
        occ_hit      = 1'b0;
        f_x          = '0;
        f_y          = '0;

        // Reset values, then quiet HOLD with a non-idle master state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(target_valid), 0);
        check("rst_addr", 32'(target_addr), 0);
        check("rst_fallback", 32'(fallback), 0);
        check("rst_occ_query", 32'(occ_query), 0);
        check("rst_occ_addr", 32'(occ_addr), 0);
        check("rst_state", 32'(dbg_state), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_valid", 32'(target_valid), 0);
        check("hold_addr", 32'(target_addr), 0);
        check("hold_state", 32'(dbg_state), 0);
        check("hold_no_query", occ_cnt, 0);

        // Plain in-range accept; query strobe visible in the CHECK cycle
        base = occ_cnt;
        issue(37, 20, 37, 20, xy(37, 20), 1'b0, LAT);
        check("search_valid_low", 32'(target_valid), 0);
        check("query_strobe", 32'(occ_query), OCC_EN);
        check("query_addr", 32'(occ_addr), (OCC_EN != 0) ? 32'(xy(37, 20)) : 32'd0);
        wait_drain(40);
        check("query_count_plain", occ_cnt - base, OCC_EN);

        // Largest legal coordinates
`ifndef TARGET_OCC_CHECK_EN
        fork
            issue(159, 119, 159, 119, xy(159, 119), 1'b0, LAT);
            begin
                repeat (6) begin
                    @(negedge clk);
                    occ_hit = 1'($urandom_range(0, 1));
                end
            end
        join
        occ_hit = 1'b0;
`else
        issue(159, 119, 159, 119, xy(159, 119), 1'b0, LAT);
`endif
        wait_drain(40);

        // X out of range on the first draw: no query, redraw
        base = occ_cnt;
        issue(200, 50, 37, 50, xy(37, 50), 1'b0, LAT + 2);
        check("reject_valid_low", 32'(target_valid), 0);
        check("reject_no_query", 32'(occ_query), 0);
        wait_drain(40);
        check("query_count_reject", occ_cnt - base, OCC_EN);

        // Y just out of range on the first draw
        issue(10, 120, 159, 0, xy(159, 0), 1'b0, LAT + 2);
        wait_drain(40);

        // Every draw out of range: forced accept folds coordinates back
        base = occ_cnt;
        issue(200, 125, 200, 125, xy(40, 5), 1'b1, 9);
        wait_drain(40);
        check("query_count_fallback", occ_cnt - base, 0);

        // Occupancy always hit
        base = occ_cnt;
        occ_hit = 1'b1;
`ifdef TARGET_OCC_CHECK_EN
        issue(10, 20, 10, 20, xy(10, 20), 1'b1, 12);
        wait_drain(40);
        check("query_count_occ_hit", occ_cnt - base, 3);
`else
        issue(10, 20, 10, 20, xy(10, 20), 1'b0, LAT);
        wait_drain(40);
        check("query_count_occ_hit", occ_cnt - base, 0);
`endif
        occ_hit = 1'b0;

        // Normal accept clears FALLBACK
        issue(1, 1, 1, 1, xy(1, 1), 1'b0, LAT);
        wait_drain(40);

        // REACHED_TARGET during a search is ignored
        issue(50, 60, 50, 60, xy(50, 60), 1'b0, LAT);
        reached = 1'b1;
        @(negedge clk);
        reached = 1'b0;
        wait_drain(40);
        repeat (15) @(negedge clk);
        check("ignore_state", 32'(dbg_state), 0);
        check("ignore_valid", 32'(target_valid), 1);
        check("ignore_addr", 32'(target_addr), 32'(xy(50, 60)));

        // Reset mid-search discards the candidate
        @(negedge clk);
        set_lfsr(XW'(70), YW'(70));
        reached = 1'b1;
        @(negedge clk);
        reached = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(target_valid), 0);
        check("midrst_addr", 32'(target_addr), 0);
        check("midrst_state", 32'(dbg_state), 0);
        check("midrst_occ_query", 32'(occ_query), 0);
        check("midrst_occ_addr", 32'(occ_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("postrst_valid", 32'(target_valid), 0);
        check("postrst_addr", 32'(target_addr), 0);

        // Free-running LFSRs: any accepted target must be on the grid
        release dut.w_lfsr_x;
        release dut.w_lfsr_y;
        issue_free();
        wait_drain(60);

        // Idle: continuous re-targeting, then frozen once play starts
        idle_phase = 1'b1;
        changes    = 0;
        last       = target_addr;
        msm        = 2'b00;
        repeat (100) begin
            @(negedge clk);
            if (target_addr != last) changes++;
            last = target_addr;
        end
        check("idle_retarget", 32'(changes >= 5), 1);
        check("idle_accepts", 32'(idle_accepts >= 5), 1);
        msm = 2'b01;
        repeat (30) @(negedge clk);
        idle_phase = 1'b0;
        changes    = 0;
        last       = target_addr;
        repeat (30) begin
            @(negedge clk);
            if (target_addr != last) changes++;
            last = target_addr;
        end
        check("frozen_changes", changes, 0);
        check("frozen_valid", 32'(target_valid), 1);
        check("frozen_state", 32'(dbg_state), 0);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
